// File: rtl/fact_arb_pkg.sv
// Shared types and default widths for the factorial-unit arbiter.
package fact_arb_pkg;

  typedef enum logic [1:0] {
    FA_IDLE  = 2'd0,
    FA_ISSUE = 2'd1,
    FA_WAIT  = 2'd2,
    FA_RESP  = 2'd3
  } fa_state_t;

  localparam int FA_IN_DATA_WD     = 3;
  localparam int FA_OUT_DATA_WD    = 16;
  localparam int FA_NUM_REQ        = 4;
  localparam int FA_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/fact_rr_picker.sv
// Combinational round-robin selector: first valid requester at or after rr_ptr.
module fact_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_WD   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_WD-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_WD-1:0]   grant_idx,
  output logic               any_valid
);

  always_comb begin
    logic [ID_WD-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    // Walk the ring starting at rr_ptr; the first hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_WD'((int'(rr_ptr) + i) % NUM_REQ);
      if (!any_valid && req[idx]) begin
        any_valid  = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fact_arbiter.sv
// Round-robin arbiter sharing one factorial unit between NUM_REQ requesters.
// Optional watchdog on the result wait: define FACT_ARB_TIMEOUT_EN.
module fact_arbiter
  import fact_arb_pkg::*;
#(
  parameter int IN_DATA_WD  = FA_IN_DATA_WD,
  parameter int OUT_DATA_WD = FA_OUT_DATA_WD,
  parameter int NUM_REQ     = FA_NUM_REQ,
  parameter int ID_WD       = $clog2(NUM_REQ)
`ifdef FACT_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = FA_TIMEOUT_CYCLES
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*IN_DATA_WD-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [IN_DATA_WD-1:0]         fact_in_data,
  output logic                          fact_in_valid,
  input  logic [OUT_DATA_WD-1:0]        fact_out_data,
  input  logic                          fact_out_valid,
  input  logic                          fact_out_busy,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_WD-1:0]              resp_id,
  output logic [OUT_DATA_WD-1:0]        resp_data,
  output logic                          resp_err,
  output logic [1:0]                    dbg_state
);

  // Handshakes: a request moves when req_valid[i] && req_ready[i] on a rising
  // edge; a response moves when resp_valid && resp_ready. Valid, once raised,
  // holds with its payload stable until the matching ready is seen.

  fa_state_t              state_q, state_d;
  logic [ID_WD-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]     pick_grant;
  logic [ID_WD-1:0]       pick_idx;
  logic                   pick_any;
  logic                   grant_fire;
  logic                   timeout_hit;
  logic [ID_WD-1:0]       id_q;
  logic [IN_DATA_WD-1:0]  req_op [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op[i] = req_data[i*IN_DATA_WD +: IN_DATA_WD];
    end
  end

  fact_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_WD   (ID_WD)
  ) u_picker (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= FA_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    grant_fire = 1'b0;
    case (state_q)
      FA_IDLE: begin
        if (!reset && pick_any && !fact_out_busy) begin
          req_ready  = pick_grant;
          grant_fire = 1'b1;
          state_d    = FA_ISSUE;
        end
      end
      FA_ISSUE: state_d = FA_WAIT;
      FA_WAIT: begin
        if (fact_out_valid || timeout_hit) state_d = FA_RESP;
      end
      FA_RESP: begin
        if (resp_ready) state_d = FA_IDLE;
      end
      default: state_d = FA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= '0;
      id_q          <= '0;
      fact_in_valid <= 1'b0;
      fact_in_data  <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
    end else begin
      // The operand register is non-zero only during the issue cycle.
      fact_in_valid <= grant_fire;
      fact_in_data  <= grant_fire ? req_op[pick_idx] : '0;
      if (grant_fire) begin
        id_q   <= pick_idx;
        rr_ptr <= (pick_idx == ID_WD'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (state_q == FA_WAIT && state_d == FA_RESP) begin
        resp_valid <= 1'b1;
        resp_data  <= fact_out_valid ? fact_out_data : '0;
      end else if (state_q == FA_RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  assign resp_id   = id_q;
  assign dbg_state = state_q;

`ifdef FACT_ARB_TIMEOUT_EN
  localparam int TMO_WD = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_WD-1:0] tmo_cnt;
  logic              err_q;

  // Counts cycles spent in WAIT; held at zero everywhere else.
  always_ff @(posedge clk) begin
    if (reset || state_q != FA_WAIT) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout_hit = (state_q == FA_WAIT) &&
                       (tmo_cnt == TMO_WD'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (state_q == FA_WAIT && state_d == FA_RESP) err_q <= !fact_out_valid;
  end

  assign resp_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fact_arbiter.sv
// Self-checking bench for fact_arbiter with a behavioural factorial unit.
// Timeout scenario is built only when FACT_ARB_TIMEOUT_EN is defined.
module tb_fact_arbiter;
  import fact_arb_pkg::*;

  localparam int IW  = 3;
  localparam int OW  = 16;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int W   = 1 + IDW + OW;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*IW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [IW-1:0]   fact_in_data;
  logic            fact_in_valid;
  logic [OW-1:0]   fact_out_data;
  logic            fact_out_valid;
  logic            fact_out_busy;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [OW-1:0]   resp_data;
  logic            resp_err;
  logic [1:0]      dbg_state;

  logic            unit_busy;
  logic            busy_force;
  bit              unit_mute;
  int              lat_override;
  int              total = 0;
  int              bad = 0;
  int              resp_cycles = 0;

  logic [W-1:0]    exp_q[$];
  logic [IW-1:0]   op_q[$];
  logic [NR-1:0]   hs_prev = '0;

  assign fact_out_busy = unit_busy | busy_force;

  always #5 clk = ~clk;

  fact_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .fact_in_data   (fact_in_data),
    .fact_in_valid  (fact_in_valid),
    .fact_out_data  (fact_out_data),
    .fact_out_valid (fact_out_valid),
    .fact_out_busy  (fact_out_busy),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_id        (resp_id),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .dbg_state      (dbg_state)
  );

  function automatic logic [OW-1:0] fact_of(int n);
    logic [OW-1:0] r;
    r = 1;
    for (int i = 2; i <= n; i++) r = r * OW'(i);
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: normal result, 1: no response expected, 2: timeout response
  task automatic send(int id, int op, int mode);
    req_data[id*IW +: IW] = IW'(op);
    req_valid[id] = 1'b1;
    if (mode != 2) op_q.push_back(IW'(op));
    if (mode == 0) exp_q.push_back({1'b0, IDW'(id), fact_of(op)});
    if (mode == 2) exp_q.push_back({1'b1, IDW'(id), OW'(0)});
  endtask

  task automatic wait_resp(int budget);
    int n;
    n = 0;
    while (!resp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) check("resp_wait_timeout", 32'(resp_valid), 1);
  endtask

  task automatic wait_drain(int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dbg_state != FA_IDLE || fact_out_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("drain_timeout", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // Requester side: drop valid one cycle after the transfer edge.
  always @(negedge clk) begin
    logic [NR-1:0] hs_now;
    hs_now    = req_valid & req_ready;
    req_valid = req_valid & ~hs_prev;
    hs_prev   = hs_now;
  end

  // Behavioural factorial unit with 1..4 cycle latency.
  always begin
    @(negedge clk);
    if (fact_in_valid && !unit_mute) begin
      logic [IW-1:0] op;
      int lat;
      op = fact_in_data;
      if (op_q.size() == 0) check("issue_unexp", 32'(op_q.size()), 1);
      else                  check("issue_op", 32'(op), 32'(op_q.pop_front()));
      lat = (lat_override > 0) ? lat_override : int'($urandom_range(1, 4));
      unit_busy = 1'b1;
      @(negedge clk);
      check("issue_pulse", 32'(fact_in_valid), 0);
      repeat (lat - 1) @(negedge clk);
      fact_out_data  = fact_of(int'(op));
      fact_out_valid = 1'b1;
      @(negedge clk);
      fact_out_valid = 1'b0;
      fact_out_data  = '0;
      unit_busy      = 1'b0;
    end
  end

  // Scoreboard consumer: compare every accepted response.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (resp_valid) resp_cycles++;
    if (resp_valid && resp_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check("resp_unexp", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("resp_id", 32'(resp_id), 32'(e[OW +: IDW]));
        check("resp_data", 32'(resp_data), 32'(e[OW-1:0]));
        check("resp_err", 32'(resp_err), 32'(e[W-1]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    reset          = 1'b1;
    req_valid      = '0;
    req_data       = '0;
    resp_ready     = 1'b1;
    fact_out_data  = '0;
    fact_out_valid = 1'b0;
    unit_busy      = 1'b0;
    busy_force     = 1'b0;
    unit_mute      = 1'b0;
    lat_override   = 0;
    cyc(3);

    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(FA_IDLE));
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_in_valid", 32'(fact_in_valid), 0);
    check("rst_in_data", 32'(fact_in_data), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_id", 32'(resp_id), 0);
    check("rst_resp_data", 32'(resp_data), 0);
    check("rst_resp_err", 32'(resp_err), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // All four at once, rr_ptr at 0: grants 0,1,2,3.
    send(0, 3, 0);
    send(1, 4, 0);
    send(2, 6, 0);
    send(3, 7, 0);
    @(negedge clk);
    check("rr_first_grant", 32'(req_ready), 32'h1);
    wait_drain(300);

    // Single request from requester 2.
    send(2, 5, 0);
    @(negedge clk);
    check("single_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    check("single_in_valid", 32'(fact_in_valid), 1);
    check("single_in_data", 32'(fact_in_data), 5);
    wait_drain(100);

    // Backpressure with another request pending.
    resp_ready = 1'b0;
    send(1, 4, 0);
    wait_resp(50);
    @(posedge clk);
    #1;
    send(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(resp_valid), 1);
      check("bp_id", 32'(resp_id), 1);
      check("bp_data", 32'(resp_data), 24);
      check("bp_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_drain(100);

    // Unit busy blocks the grant until it drops.
    busy_force = 1'b1;
    send(0, 3, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_nogrant", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1 busy_force = 1'b0;
    @(negedge clk);
    check("busy_grant", 32'(req_ready), 32'h1);
    wait_drain(100);

    // Reset in WAIT; the late result must be ignored.
    lat_override = 8;
    send(3, 2, 1);
    n = 0;
    while (dbg_state != FA_WAIT && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait", 32'(dbg_state), 32'(FA_WAIT));
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("wrst_state", 32'(dbg_state), 32'(FA_IDLE));
    check("wrst_in_valid", 32'(fact_in_valid), 0);
    check("wrst_resp_valid", 32'(resp_valid), 0);
    check("wrst_resp_id", 32'(resp_id), 0);
    check("wrst_resp_data", 32'(resp_data), 0);
    check("wrst_req_ready", 32'(req_ready), 0);
    base = resp_cycles;
    cyc(15);
    check("late_ignored", 32'(resp_cycles - base), 0);
    check("late_state", 32'(dbg_state), 32'(FA_IDLE));
    lat_override = 0;
    wait_drain(100);

    // Random single requests with random response stalls.
    for (int k = 0; k < 8; k++) begin
      int id, op, stall;
      id    = int'($urandom_range(0, NR - 1));
      op    = int'($urandom_range(0, 7));
      stall = int'($urandom_range(0, 3));
      resp_ready = (stall == 0);
      send(id, op, 0);
      if (stall != 0) begin
        wait_resp(50);
        cyc(stall);
        resp_ready = 1'b1;
      end
      wait_drain(100);
    end

`ifdef FACT_ARB_TIMEOUT_EN
    unit_mute = 1'b1;
    send(1, 3, 2);
    n = 0;
    base = 0;
    while (!resp_valid && n < 300) begin
      @(negedge clk);
      if (dbg_state == FA_WAIT) base++;
      n++;
    end
    check("tmo_wait_cycles", 32'(base), 64);
    wait_drain(100);
    unit_mute = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fact_arbiter.md
# fact_arbiter

Shares a single factorial computation unit between `NUM_REQ` requesters. Accepts one request at a time with round-robin fairness, issues it to the factorial unit's `in_data`/`in_valid` port, waits for `out_valid`, and returns the result with the requester's ID on a valid/ready response channel. Sits between the requester-side fabric and the factorial datapath.

## Interface
- `IN_DATA_WD`, 3: operand width (n in n!).
- `OUT_DATA_WD`, 16: result width.
- `NUM_REQ`, 4: number of requesters, ≥2.
- `ID_WD`, `$clog2(NUM_REQ)`: requester ID width.
- `TIMEOUT_CYCLES`, 64: watchdog limit; used only with `FACT_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_data`  in  NUM_REQ×IN_DATA_WD  per-requester operand.
- `req_ready`  out  NUM_REQ  one-hot grant; a request transfers when valid and ready are both high.
- `fact_in_data`  out  IN_DATA_WD  operand to the factorial unit.
- `fact_in_valid`  out  1  one-cycle start pulse.
- `fact_out_data`  in  OUT_DATA_WD  factorial result.
- `fact_out_valid`  in  1  result strobe, one cycle.
- `fact_out_busy`  in  1  factorial unit busy.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response accept.
- `resp_id`  out  ID_WD  index of the requester that owns the response.
- `resp_data`  out  OUT_DATA_WD  result.
- `resp_err`  out  1  timeout flag; constant 0 without the macro.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when any `req_valid` is high and `fact_out_busy`=0, the round-robin picker selects the first valid requester at or after `rr_ptr`. `req_ready[g]`=1 combinationally in that cycle only. Operand and ID are latched, `rr_ptr` ← (g+1) mod NUM_REQ, next state is ISSUE. When `fact_out_busy`=1, no grant is made.
- ISSUE: `fact_in_valid`=1 and `fact_in_data`=latched operand for exactly one cycle, then WAIT.
- WAIT: on `fact_out_valid`=1, capture `fact_out_data`, then RESP.
- RESP: `resp_valid`=1. `resp_id`, `resp_data` and `resp_err` are held stable until `resp_ready`=1, then IDLE.
- `req_ready` is all-zero outside IDLE. Requests that arrive while the arbiter is busy wait with their valid held and are not dropped.
- `fact_out_valid` outside WAIT is ignored.
- Results pass through unmodified, including for operand 0 (0! = 1, produced by the unit).
- Reset in any state: state=IDLE, `rr_ptr`=0. All outputs are 0: `req_ready`, `fact_in_valid`, `fact_in_data`, `resp_valid`, `resp_id`, `resp_data`, `resp_err`. An in-flight transaction is abandoned. A late `fact_out_valid` after reset is ignored under the rule above.

## Timing
- Grant in cycle T, `fact_in_valid` in T+1. If `fact_out_valid` arrives in cycle T+1+L, `resp_valid` rises in T+2+L.
- Response handshake in cycle R returns the FSM to IDLE in R+1. The earliest next grant is R+1.
- The unit sees at most one outstanding operation. Throughput is one request per (L+3+response stall) cycles.
- Outputs toward the factorial unit and the response channel are registered. `req_ready` is the only combinational output (from state, `req_valid`, `rr_ptr`, `fact_out_busy`).
- Simultaneous requests: strict round-robin. A requester holding `req_valid` is granted within NUM_REQ transactions.

## Configuration
- `FACT_ARB_TIMEOUT_EN` defined: a counter runs in WAIT. If `TIMEOUT_CYCLES` cycles elapse without `fact_out_valid`, go to RESP with `resp_err`=1 and `resp_data`=0. The counter clears on entry to WAIT.
- Macro undefined: no counter, WAIT has no time limit, `resp_err` is tied to 0.

## Structure
- `fact_arb_pkg`: FSM state enum (`FA_IDLE`, `FA_ISSUE`, `FA_WAIT`, `FA_RESP`) and default width localparams.
- Sub-module `fact_rr_picker`: combinational round-robin selector. Inputs are the request vector and `rr_ptr`. Outputs are a one-hot grant, the grant index, and an any-valid flag.

## Test plan
- Single request: requester 2 sends 5 → one `fact_in_valid` pulse with data 5; response `resp_id`=2, `resp_data`=120, `resp_err`=0.
- All four valid at once with operands 3, 4, 6, 7 and `rr_ptr`=0 → grants in order 0, 1, 2, 3; responses 6, 24, 720, 5040.
- Backpressure: hold `resp_ready`=0 for 10 cycles → `resp_valid`, `resp_id` and `resp_data` stay stable; no new grant occurs; `req_ready` is 0 throughout.
- `fact_out_busy`=1 with request 0 pending → no grant; grant in the first cycle `fact_out_busy` is 0. Operand 0 → `resp_data`=1.
- Reset asserted in WAIT → next cycle is IDLE with all outputs 0; a later `fact_out_valid` produces no response.
- With `FACT_ARB_TIMEOUT_EN`: the unit never answers → after 64 cycles in WAIT, response with `resp_err`=1 and `resp_data`=0.
